// File: rtl/imem_responder_pkg.sv
// Shared IF-stage definitions: the fetch NOP encoding and the response
// record carried by every stage of the instruction-memory response pipeline.
package imem_responder_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic        err;
      logic [31:0] data;
   } imem_resp_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port and one write port.
// The read register only loads when rd_en is set, so it holds across stalls.
module imem_array
   import imem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data
);

   logic [31:0] mem [DEPTH_WORDS];

   // Both updates are non-blocking, so a same-edge read returns the pre-write word.
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_idx];
      if (wr_en) mem[wr_idx] <= wr_data;
   end

endmodule

// File: rtl/imem_responder.sv
// Memory side of the fetch interface: accepts one request per cycle and
// returns the tagged instruction LATENCY cycles later, with stall and flush.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] NOP_INST    = imem_responder_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic [31:0] rd_addr,
   input  logic        stall,
   input  logic        flush,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_addr,
   output logic        inst_err
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

   logic        accept;
   logic        rd_err;
   logic        wr_ok;
   logic [31:0] rd_data;
   imem_resp_t  pipe [LATENCY];
   imem_resp_t  view [LATENCY];
   imem_resp_t  out;

   assign accept = rd_en & ~stall & ~flush & ~rst;
   assign rd_err = (rd_addr[1:0] != 2'b00) | (rd_addr >= ADDR_LIMIT);
   assign wr_ok  = wr_en & (wr_addr < ADDR_LIMIT);

   imem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_array (
      .clk    (clk),
      .rd_en  (accept),
      .rd_idx (rd_addr[AW+1:2]),
      .rd_data(rd_data),
      .wr_en  (wr_ok),
      .wr_idx (wr_addr[AW+1:2]),
      .wr_data(wr_data)
   );

   // Stage 0 data lives in the array's read register; every later stage keeps its own copy.
   always_comb begin
      view         = pipe;
      view[0].data = rd_data;
   end

   // Invalid entries never overwrite a stage's address, so inst_addr holds across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe[i].valid <= 1'b0;
            pipe[i].addr  <= '0;
            pipe[i].err   <= 1'b0;
         end
      end else if (flush) begin
         for (int i = 0; i < LATENCY; i++) pipe[i].valid <= 1'b0;
      end else if (!stall) begin
         pipe[0].valid <= accept;
         if (accept) begin
            pipe[0].addr <= rd_addr;
            pipe[0].err  <= rd_err;
            pipe[0].data <= NOP_INST;
         end
         for (int i = 1; i < LATENCY; i++) begin
            pipe[i].valid <= view[i-1].valid;
            if (view[i-1].valid) begin
               pipe[i].addr <= view[i-1].addr;
               pipe[i].err  <= view[i-1].err;
               pipe[i].data <= view[i-1].data;
            end
         end
      end
   end

   assign out        = view[LATENCY-1];
   assign inst_valid = out.valid;
   assign inst_addr  = out.addr;
   assign inst_err   = out.valid & out.err;
   assign inst       = (out.valid & ~out.err) ? out.data : NOP_INST;

endmodule
